// File: rtl/glitch_pkg.sv
// ============================================================================
// Module   : glitch_pkg
// Purpose  : Shared definitions for the glitch tool chain: outcome class
//            encodings, the common timing-counter width and the outcome
//            monitor state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package glitch_pkg;

  // Width of every clk-cycle timing quantity (offsets, windows, delays).
  // The glitch generator sizes its own delay counters with this too.
  localparam int TIME_W  = 28;

  // Width of the reported glitch low time.
  localparam int WIDTH_W = 16;

  // Outcome classes as reported on res_class.
  localparam logic [1:0] CLS_NORMAL  = 2'd0;
  localparam logic [1:0] CLS_SUCCESS = 2'd1;
  localparam logic [1:0] CLS_CRASH   = 2'd2;

  // Outcome monitor states.
  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_MEASURE = 3'd2,
    ST_WINDOW  = 3'd3,
    ST_REPORT  = 3'd4,
    ST_PWRCYC  = 3'd5
  } state_t;

endpackage : glitch_pkg

`default_nettype wire

// File: rtl/glitch_outcome_monitor_if.sv
// ============================================================================
// Module   : glitch_outcome_monitor_if
// Purpose  : Valid/ready result record port of the glitch outcome monitor.
// Ports    : res_valid  - record valid (producer)
//            res_ready  - record accepted (consumer)
//            res_class  - outcome class
//            res_offset - clk cycles from previous glitch end to glitch start
//            res_width  - glitch low time in clk cycles, saturating
//            master modport = monitor side, slave modport = consumer side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface glitch_outcome_monitor_if;

  logic                               res_valid;
  logic                               res_ready;
  logic [1:0]                         res_class;
  logic [glitch_pkg::TIME_W-1:0]      res_offset;
  logic [glitch_pkg::WIDTH_W-1:0]     res_width;

  modport master (
    output res_valid,
    output res_class,
    output res_offset,
    output res_width,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_class,
    input  res_offset,
    input  res_width,
    output res_ready
  );

endinterface : glitch_outcome_monitor_if

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module   : sync_edge
// Purpose  : Multi-flop synchroniser for an asynchronous input, with
//            single-cycle rise, fall and any-edge pulses derived from the
//            synchronised level.
// Ports    : clk      - system clock
//            rst      - asynchronous active-high reset
//            i_async  - asynchronous input
//            o_sync   - synchronised level
//            o_rise   - one-cycle pulse on synchronised 0->1
//            o_fall   - one-cycle pulse on synchronised 1->0
//            o_edge   - one-cycle pulse on any synchronised change
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_async,
  output logic      o_sync,
  output logic      o_rise,
  output logic      o_fall,
  output logic      o_edge
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Reset value matches the input's idle level so that leaving reset does
  // not manufacture an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;
  assign o_edge = r_sync[STAGES-1] ^ r_prev;

endmodule : sync_edge

`default_nettype wire

// File: rtl/glitch_outcome_monitor.sv
// ============================================================================
// Module   : glitch_outcome_monitor
// Purpose  : Target-side monitor for a ground-line glitch sweep. Measures
//            each glitch (width and offset from the previous glitch end),
//            watches the target for WINDOW cycles afterwards and classifies
//            the response as NORMAL / SUCCESS / CRASH. Results go out on a
//            valid/ready record port and into saturating per-class counters.
//            A crash power-cycles the target through pow.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            glitch_n        - glitch strobe, low = active (async)
//            target_hb       - target heartbeat, any edge = alive (async)
//            target_success  - target fault-success flag (async)
//            res             - result record port (master modport)
//            pow             - target power enable, 1 = on
//            busy            - high in every state except IDLE
//            cnt_normal/success/crash/missed - saturating outcome counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module glitch_outcome_monitor
  import glitch_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [TIME_W-1:0] WINDOW      = 28'd12000000,
  parameter logic [TIME_W-1:0] PWR_OFF     = 28'd1200000,
  parameter logic [TIME_W-1:0] BOOT_WAIT   = 28'd24000000,
  parameter int                CNT_W       = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  glitch_n,
  input  wire logic                  target_hb,
  input  wire logic                  target_success,
  glitch_outcome_monitor_if.master   res,
  output logic                       pow,
  output logic                       busy,
  output logic [CNT_W-1:0]           cnt_normal,
  output logic [CNT_W-1:0]           cnt_success,
  output logic [CNT_W-1:0]           cnt_crash,
  output logic [CNT_W-1:0]           cnt_missed
);

  localparam logic [TIME_W-1:0]  C_T_ONE = {{(TIME_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_W-1:0] C_W_ONE = {{(WIDTH_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   C_C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic w_g_sync, w_gend, w_gstart, w_g_edge;
  logic w_hb_sync, w_hb_rise, w_hb_fall, w_hb_edge;
  logic w_sc_sync, w_sc_rise, w_sc_fall, w_sc_edge;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_glitch (
    .clk     (clk),
    .rst     (rst),
    .i_async (glitch_n),
    .o_sync  (w_g_sync),
    .o_rise  (w_gend),
    .o_fall  (w_gstart),
    .o_edge  (w_g_edge)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_hb (
    .clk     (clk),
    .rst     (rst),
    .i_async (target_hb),
    .o_sync  (w_hb_sync),
    .o_rise  (w_hb_rise),
    .o_fall  (w_hb_fall),
    .o_edge  (w_hb_edge)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_success (
    .clk     (clk),
    .rst     (rst),
    .i_async (target_success),
    .o_sync  (w_sc_sync),
    .o_rise  (w_sc_rise),
    .o_fall  (w_sc_fall),
    .o_edge  (w_sc_edge)
  );

  // Synchroniser outputs this block has no use for.
  logic w_unused;
  assign w_unused = ^{w_g_edge, w_hb_sync, w_hb_rise, w_hb_fall,
                      w_sc_rise, w_sc_fall, w_sc_edge};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              r_state, w_state_n;
  logic [TIME_W-1:0]   r_tcnt;      // shared BOOT / WINDOW / PWRCYC timer
  logic [TIME_W-1:0]   r_offset;    // cycles since last glitch end
  logic [TIME_W-1:0]   r_res_offset;
  logic [WIDTH_W-1:0]  r_width;
  logic [1:0]          r_class;
  logic                r_res_valid;
  logic                r_seen_hb;
  logic                r_seen_succ;
  logic                r_pow;
  logic                r_busy;
  logic [CNT_W-1:0]    r_cnt_normal, r_cnt_success, r_cnt_crash, r_cnt_missed;

  logic                w_timed;
  logic                w_hs;
  logic                w_missed;
  logic                w_boot_exit;
  logic                w_win_end;
  logic [1:0]          w_cls_now;

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n   = r_state;
    w_timed     = 1'b0;
    w_boot_exit = 1'b0;
    w_win_end   = 1'b0;
    w_hs        = r_res_valid & res.res_ready;
    w_missed    = w_gstart & (r_state != ST_IDLE);

    // Current-cycle inputs are folded in so a success flag or heartbeat
    // arriving on the very last window cycle still counts.
    if (r_seen_succ || w_sc_sync) begin
      w_cls_now = CLS_SUCCESS;
    end else if (r_seen_hb || w_hb_edge) begin
      w_cls_now = CLS_NORMAL;
    end else begin
      w_cls_now = CLS_CRASH;
    end

    case (r_state)
      ST_BOOT: begin
        w_timed = 1'b1;
        if (r_tcnt == BOOT_WAIT - C_T_ONE) begin
          w_state_n   = ST_IDLE;
          w_boot_exit = 1'b1;
        end
      end
      ST_IDLE: begin
        if (w_gstart) w_state_n = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (w_gend) w_state_n = ST_WINDOW;
      end
      ST_WINDOW: begin
        w_timed = 1'b1;
        if (r_tcnt == WINDOW - C_T_ONE) begin
          w_state_n = ST_REPORT;
          w_win_end = 1'b1;
        end
      end
      ST_REPORT: begin
        if (w_hs) w_state_n = (r_class == CLS_CRASH) ? ST_PWRCYC : ST_IDLE;
      end
      ST_PWRCYC: begin
        w_timed = 1'b1;
        if (r_tcnt == PWR_OFF - C_T_ONE) w_state_n = ST_BOOT;
      end
      default: w_state_n = ST_BOOT;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and phase timer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_state_n != r_state) begin
        r_tcnt <= '0;
      end else if (w_timed) begin
        r_tcnt <= r_tcnt + C_T_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Measurement, result record and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_offset      <= '0;
      r_res_offset  <= '0;
      r_width       <= '0;
      r_class       <= CLS_NORMAL;
      r_res_valid   <= 1'b0;
      r_seen_hb     <= 1'b0;
      r_seen_succ   <= 1'b0;
      r_pow         <= 1'b1;
      r_busy        <= 1'b0;
      r_cnt_normal  <= '0;
      r_cnt_success <= '0;
      r_cnt_crash   <= '0;
      r_cnt_missed  <= '0;
    end else begin
      // Offset restarts at every glitch end (measured or missed) and at
      // BOOT exit, so the first glitch after a reboot is timed from there.
      if (w_gend || w_boot_exit) begin
        r_offset <= '0;
      end else if (r_offset != '1) begin
        r_offset <= r_offset + C_T_ONE;
      end

      if (r_state == ST_IDLE && w_gstart) begin
        r_res_offset <= r_offset;
        r_width      <= C_W_ONE;
      end

      if (r_state == ST_MEASURE) begin
        if (w_gend) begin
          r_seen_hb   <= 1'b0;
          r_seen_succ <= 1'b0;
        end else if (!w_g_sync && r_width != '1) begin
          r_width <= r_width + C_W_ONE;
        end
      end

      if (r_state == ST_WINDOW) begin
        r_seen_hb   <= r_seen_hb | w_hb_edge;
        r_seen_succ <= r_seen_succ | w_sc_sync;
        if (w_win_end) begin
          r_class     <= w_cls_now;
          r_res_valid <= 1'b1;
        end
      end

      if (r_state == ST_REPORT && w_hs) begin
        r_res_valid <= 1'b0;
        case (r_class)
          CLS_SUCCESS: if (r_cnt_success != '1) r_cnt_success <= r_cnt_success + C_C_ONE;
          CLS_CRASH:   if (r_cnt_crash   != '1) r_cnt_crash   <= r_cnt_crash   + C_C_ONE;
          default:     if (r_cnt_normal  != '1) r_cnt_normal  <= r_cnt_normal  + C_C_ONE;
        endcase
      end

      if (w_missed && r_cnt_missed != '1) begin
        r_cnt_missed <= r_cnt_missed + C_C_ONE;
      end

      // Registered from the next state so pow and busy line up exactly with
      // the state they describe.
      r_pow  <= (w_state_n != ST_PWRCYC);
      r_busy <= (w_state_n != ST_IDLE);
    end
  end

  assign res.res_valid  = r_res_valid;
  assign res.res_class  = r_class;
  assign res.res_offset = r_res_offset;
  assign res.res_width  = r_width;
  assign pow            = r_pow;
  assign busy           = r_busy;
  assign cnt_normal     = r_cnt_normal;
  assign cnt_success    = r_cnt_success;
  assign cnt_crash      = r_cnt_crash;
  assign cnt_missed     = r_cnt_missed;

endmodule : glitch_outcome_monitor

`default_nettype wire

// File: tb/tb_glitch_outcome_monitor.sv
// ============================================================================
// Module   : tb_glitch_outcome_monitor
// Purpose  : Directed self-checking bench for glitch_outcome_monitor with
//            WINDOW = 100, PWR_OFF = 20, BOOT_WAIT = 50, SYNC_STAGES = 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_glitch_outcome_monitor;
  import glitch_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             glitch_n = 1'b1;
  logic             target_hb = 1'b0;
  logic             target_success = 1'b0;
  logic             pow;
  logic             busy;
  logic [CNT_W-1:0] cnt_normal, cnt_success, cnt_crash, cnt_missed;

  logic             hb_en = 1'b0;
  int               hb_cnt = 0;
  int               n_tests = 0;
  int               n_fail = 0;
  int               n;
  int               n_low;
  int               n_boot;

  glitch_outcome_monitor_if u_if ();

  glitch_outcome_monitor #(
    .SYNC_STAGES (2),
    .WINDOW      (28'd100),
    .PWR_OFF     (28'd20),
    .BOOT_WAIT   (28'd50),
    .CNT_W       (CNT_W)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .glitch_n       (glitch_n),
    .target_hb      (target_hb),
    .target_success (target_success),
    .res            (u_if),
    .pow            (pow),
    .busy           (busy),
    .cnt_normal     (cnt_normal),
    .cnt_success    (cnt_success),
    .cnt_crash      (cnt_crash),
    .cnt_missed     (cnt_missed)
  );

  always #5 clk = ~clk;

  // Heartbeat: toggles every 30 cycles while enabled.
  initial begin : p_hb
    forever begin
      @(posedge clk);
      #1;
      if (hb_en) begin
        hb_cnt++;
        if (hb_cnt == 30) begin
          hb_cnt    = 0;
          target_hb = ~target_hb;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic glitch(input int len);
    glitch_n = 1'b0;
    repeat (len) tick();
    glitch_n = 1'b1;
  endtask

  // Ticks from glitch release until res_valid; bounded.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!u_if.res_valid && cycles < 500) begin
      tick();
      cycles++;
    end
    if (!u_if.res_valid) check("wait_valid_timeout", 32'(u_if.res_valid), 32'd1);
  endtask

  task automatic handshake();
    u_if.res_ready = 1'b1;
    tick();
    u_if.res_ready = 1'b0;
  endtask

  initial begin : p_main
    u_if.res_ready = 1'b0;

    // ---------------- reset values ----------------
    repeat (3) tick();
    check("rst_valid",  32'(u_if.res_valid),  32'd0);
    check("rst_class",  32'(u_if.res_class),  32'd0);
    check("rst_offset", 32'(u_if.res_offset), 32'd0);
    check("rst_width",  32'(u_if.res_width),  32'd0);
    check("rst_pow",    32'(pow),             32'd1);
    check("rst_busy",   32'(busy),            32'd0);
    check("rst_cnt",    32'({cnt_normal, cnt_success} | {cnt_crash, cnt_missed}), 32'd0);
    rst = 1'b0;

    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 200);
    check("boot_len", n, 50);

    // ---------------- T1: normal glitch ----------------
    hb_en = 1'b1;
    glitch(1500);
    wait_valid(n);
    check("t1_latency", n, 103);
    check("t1_class",   32'(u_if.res_class),  32'(CLS_NORMAL));
    check("t1_width",   32'(u_if.res_width),  32'd1500);
    check("t1_offset",  32'(u_if.res_offset), 32'd2);
    check("t1_pow",     32'(pow),             32'd1);
    check("t1_busy",    32'(busy),            32'd1);
    check("t1_cnt_pre", 32'(cnt_normal),      32'd0);
    handshake();
    check("t1_valid_low", 32'(u_if.res_valid), 32'd0);
    check("t1_cnt",       32'(cnt_normal),     32'd1);
    check("t1_idle",      32'(busy),           32'd0);

    // ---------------- T2: success on last window cycle ----------------
    glitch(10);
    repeat (100) tick();
    target_success = 1'b1;
    tick();
    target_success = 1'b0;
    tick();
    check("t2_not_early", 32'(u_if.res_valid), 32'd0);
    tick();
    check("t2_valid",   32'(u_if.res_valid),  32'd1);
    check("t2_class",   32'(u_if.res_class),  32'(CLS_SUCCESS));
    check("t2_width",   32'(u_if.res_width),  32'd10);
    check("t2_offset",  32'(u_if.res_offset), 32'd103);
    handshake();
    check("t2_cnt_succ",   32'(cnt_success), 32'd1);
    check("t2_cnt_normal", 32'(cnt_normal),  32'd1);

    // ---------------- T3: backpressure + missed glitch ----------------
    u_if.res_ready = 1'b1;
    repeat (3) tick();
    u_if.res_ready = 1'b0;
    check("t3_ready_ignored", 32'({cnt_normal, cnt_success}), {16'd1, 16'd1});
    glitch(20);
    wait_valid(n);
    for (int i = 0; i < 40; i++) begin
      if (i == 10) glitch_n = 1'b0;
      if (i == 20) glitch_n = 1'b1;
      tick();
      check("t3_hold_valid", 32'(u_if.res_valid), 32'd1);
      check("t3_hold_class", 32'(u_if.res_class), 32'(CLS_NORMAL));
      check("t3_hold_width", 32'(u_if.res_width), 32'd20);
    end
    check("t3_cnt_pre", 32'(cnt_normal), 32'd1);
    check("t3_missed",  32'(cnt_missed), 32'd1);
    handshake();
    check("t3_cnt",       32'(cnt_normal),     32'd2);
    check("t3_valid_low", 32'(u_if.res_valid), 32'd0);

    // ---------------- T5: width saturation ----------------
    glitch(70000);
    wait_valid(n);
    check("t5_width", 32'(u_if.res_width), 32'h0000_FFFF);
    check("t5_class", 32'(u_if.res_class), 32'(CLS_NORMAL));
    handshake();
    check("t5_cnt", 32'(cnt_normal), 32'd3);

    // ---------------- T4: crash and power cycle ----------------
    hb_en = 1'b0;
    repeat (5) tick();
    glitch(5);
    wait_valid(n);
    check("t4_class", 32'(u_if.res_class), 32'(CLS_CRASH));
    check("t4_width", 32'(u_if.res_width), 32'd5);
    check("t4_pow_pre", 32'(pow), 32'd1);
    handshake();
    check("t4_cnt_crash", 32'(cnt_crash), 32'd1);
    n_low = 0;
    while (pow == 1'b0 && n_low < 100) begin
      check("t4_busy_pwr", 32'(busy), 32'd1);
      n_low++;
      tick();
    end
    check("t4_pow_low_len", n_low, 20);
    n_boot = 0;
    while (busy && n_boot < 200) begin
      check("t4_pow_boot", 32'(pow), 32'd1);
      tick();
      n_boot++;
    end
    check("t4_boot_len", n_boot, 50);
    check("t4_missed",   32'(cnt_missed), 32'd1);

    // ---------------- T6: async reset mid-window ----------------
    glitch(5);
    repeat (50) tick();
    check("t6_busy_win", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid",  32'(u_if.res_valid), 32'd0);
    check("t6_busy",   32'(busy),           32'd0);
    check("t6_pow",    32'(pow),            32'd1);
    check("t6_class",  32'(u_if.res_class), 32'd0);
    check("t6_width",  32'(u_if.res_width), 32'd0);
    check("t6_offset", 32'(u_if.res_offset), 32'd0);
    check("t6_cnts",   32'({cnt_normal, cnt_crash} | {cnt_success, cnt_missed}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_glitch_outcome_monitor

`default_nettype wire
